// File: rtl/abs_diff_err_monitor.sv
// Sweeps all 16 vectors through a 2-bit |a-b| approximate circuit and scores its error.
// Optional ABS_DIFF_MON_SUM_EN adds the err_sum port and its accumulator.
module abs_diff_err_monitor #(
  parameter int ET      = 1,
  parameter int DUT_LAT = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [3:0] stim_o,
  input  logic [1:0] approx_i,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [1:0] max_err,
  output logic [4:0] viol_cnt,
  output logic [1:0] fsm_state
`ifdef ABS_DIFF_MON_SUM_EN
  ,
  output logic [5:0] err_sum
`endif
);

  localparam int CW = (DUT_LAT > 0) ? $clog2(DUT_LAT + 1) : 1;
  localparam logic [CW-1:0] LAT_MAX = CW'(DUT_LAT);
  localparam logic [1:0] ET_L = 2'(ET);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t state;
  logic [CW-1:0] wait_cnt;

  logic [1:0] a, b, exact, err, max_nxt;
  logic signed [2:0] diff;
  logic [4:0] viol_nxt;

  assign fsm_state = state;

  // Exact |a-b| through a signed 3-bit difference, then error against the circuit.
  always_comb begin
    a        = stim_o[1:0];
    b        = stim_o[3:2];
    diff     = $signed({1'b0, a}) - $signed({1'b0, b});
    exact    = diff[2] ? 2'(-diff) : diff[1:0];
    err      = (exact >= approx_i) ? (exact - approx_i) : (approx_i - exact);
    max_nxt  = (err > max_err) ? err : max_err;
    viol_nxt = viol_cnt + {4'd0, (err > ET_L)};
  end

`ifdef ABS_DIFF_MON_SUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_sum <= '0;
    end else if ((state != RUN) && start) begin
      err_sum <= '0;
    end else if ((state == RUN) && (wait_cnt == LAT_MAX)) begin
      err_sum <= err_sum + {4'd0, err};
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      wait_cnt <= '0;
      stim_o   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      pass     <= 1'b0;
      max_err  <= '0;
      viol_cnt <= '0;
    end else begin
      case (state)
        IDLE, DONE: begin
          if (start) begin
            state    <= RUN;
            wait_cnt <= '0;
            stim_o   <= '0;
            busy     <= 1'b1;
            done     <= 1'b0;
            pass     <= 1'b0;
            max_err  <= '0;
            viol_cnt <= '0;
          end
        end
        RUN: begin
          // start is deliberately ignored here; a sweep always runs to completion.
          if (wait_cnt == LAT_MAX) begin
            max_err  <= max_nxt;
            viol_cnt <= viol_nxt;
            wait_cnt <= '0;
            if (stim_o == 4'hF) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
              pass  <= (viol_nxt == 5'd0);
            end else begin
              stim_o <= stim_o + 4'd1;
            end
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
